ex_alu_stage: RTL and testbench

Execute-stage ALU for the RISC-V pipeline datapath. It consumes the 4-bit `operation` code produced by the ALU control unit together with two register operands, computes the result, and holds it in a registered EX/MEM-facing output with a valid/ready handshake. Single-cycle ops complete in one clock. An optional iterative shift-add multiplier adds a multi-cycle busy state. A flush input supports branch squash from the hazard unit.

---
 rtl/ex_alu_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_ex_alu_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute-stage ALU for the RISC-V pipeline datapath.
//
// Purpose:
//   Computes AND/OR/ADD/SUB/SLT/NOR on two XLEN-bit operands selected by the
//   4-bit ALU control code. The result goes into an EX/MEM-facing output
//   register with a valid/ready handshake. Unsupported codes still produce a
//   result (0) flagged as illegal. When the EX_ALU_MUL_EN macro is defined, an
//   iterative shift-add multiplier (one bit per cycle) handles code 1000.
//   Without the macro, code 1000 is illegal. A flush input squashes held and
//   in-flight work.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   ID/EX offers an operation
//   in_ready   stage accepts this cycle (combinational)
//   operation  ALU control code
//   a, b       operands
//   rd_in      destination register tag
//   flush      squash in-flight and held work
//   out_valid  result register holds a valid result
//   out_ready  downstream accepts result
//   result     registered result
//   zero       registered, result == 0
//   illegal    registered, unsupported operation
//   rd_out     registered destination tag
//
// Configuration macro: EX_ALU_MUL_EN (enables the MUL state and datapath).

module ex_alu_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      operation,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [4:0]      rd_out
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

`ifdef EX_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CNT_W  = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0
  } state_t;
`endif

  state_t            state_r;
  state_t            state_next_s;
  logic              accept_s;
  logic [XLEN-1:0]   alu_res_s;
  logic              alu_illegal_s;
  logic              load_s;
  logic [XLEN-1:0]   load_res_s;
  logic              load_illegal_s;
  logic [4:0]        load_rd_s;

`ifdef EX_ALU_MUL_EN
  logic              is_mul_s;
  logic              mul_done_s;
  logic [XLEN-1:0]   mul_step_s;
  logic [XLEN-1:0]   mcand_r;
  logic [XLEN-1:0]   mplier_r;
  logic [XLEN-1:0]   acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [4:0]        rd_mul_r;

  assign is_mul_s   = (operation == OP_MUL);
  assign mul_done_s = (state_r == ST_MUL) && (cnt_r == CNT_LAST);
  // Partial-product accumulation for the multiplier bit examined this cycle.
  assign mul_step_s = acc_r + (mplier_r[0] ? mcand_r : {XLEN{1'b0}});
`endif

  // A new operation is taken only when the output slot is (or is becoming) free.
  assign in_ready = !flush && (state_r == ST_IDLE) && (!out_valid || out_ready);
  assign accept_s = in_valid && in_ready;

  // Single-cycle ALU datapath and legality decode.
  always_comb begin
    alu_res_s     = {XLEN{1'b0}};
    alu_illegal_s = 1'b0;
    case (operation)
      OP_AND: alu_res_s = a & b;
      OP_OR:  alu_res_s = a | b;
      OP_ADD: alu_res_s = a + b;
      OP_SUB: alu_res_s = a - b;
      OP_SLT: alu_res_s = ($signed(a) < $signed(b)) ? {{(XLEN-1){1'b0}}, 1'b1} : {XLEN{1'b0}};
      OP_NOR: alu_res_s = ~(a | b);
`ifdef EX_ALU_MUL_EN
      // The product is delivered by the multiplier, not this path.
      OP_MUL: alu_res_s = {XLEN{1'b0}};
`endif
      default: begin
        alu_res_s     = {XLEN{1'b0}};
        alu_illegal_s = 1'b1;
      end
    endcase
  end

  // Select what (if anything) loads the output register this cycle.
  always_comb begin
    load_s         = 1'b0;
    load_res_s     = {XLEN{1'b0}};
    load_illegal_s = 1'b0;
    load_rd_s      = 5'd0;
`ifdef EX_ALU_MUL_EN
    if (mul_done_s) begin
      load_s     = 1'b1;
      load_res_s = mul_step_s;
      load_rd_s  = rd_mul_r;
    end else if (accept_s && !is_mul_s) begin
      load_s         = 1'b1;
      load_res_s     = alu_res_s;
      load_illegal_s = alu_illegal_s;
      load_rd_s      = rd_in;
    end else begin
      load_s = 1'b0;
    end
`else
    if (accept_s) begin
      load_s         = 1'b1;
      load_res_s     = alu_res_s;
      load_illegal_s = alu_illegal_s;
      load_rd_s      = rd_in;
    end else begin
      load_s = 1'b0;
    end
`endif
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
`ifdef EX_ALU_MUL_EN
        ST_IDLE: begin
          if (accept_s && is_mul_s) begin
            state_next_s = ST_MUL;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_r == CNT_LAST) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_MUL;
          end
        end
`else
        ST_IDLE: state_next_s = ST_IDLE;
`endif
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

`ifdef EX_ALU_MUL_EN
  // Multiplier operands, accumulator and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= {XLEN{1'b0}};
      mplier_r <= {XLEN{1'b0}};
      acc_r    <= {XLEN{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      rd_mul_r <= 5'd0;
    end else if (accept_s && is_mul_s) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {XLEN{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      rd_mul_r <= rd_in;
    end else if (state_r == ST_MUL) begin
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      acc_r    <= mul_step_s;
      cnt_r    <= cnt_r + CNT_W'(1);
    end
  end
`endif

  // Output register: flush beats load; load beats drain; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= {XLEN{1'b0}};
      zero      <= 1'b0;
      illegal   <= 1'b0;
      rd_out    <= 5'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_s) begin
      out_valid <= 1'b1;
      result    <= load_res_s;
      zero      <= (load_res_s == {XLEN{1'b0}});
      illegal   <= load_illegal_s;
      rd_out    <= load_rd_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
module tb_ex_alu_stage;

`ifdef EX_ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  operation = 4'd0;
  logic [63:0] a = 64'd0;
  logic [63:0] b = 64'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        zero;
  logic        illegal;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid;
  logic [63:0] m_result;
  bit          m_zero;
  bit          m_illegal;
  logic [4:0]  m_rd;
  bit          m_fresh;     // just reset: data fields must be zero
  int          m_mul_left;  // remaining MUL cycles, 0 = not busy
  logic [63:0] m_mul_res;
  logic [4:0]  m_mul_rd;

  ex_alu_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .a(a), .b(b), .rd_in(rd_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                                  output logic [63:0] r, output bit ill);
    ill = 1'b0;
    r   = 64'd0;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'b1100: r = ~(x | y);
      4'b1000: begin
        if (MUL_ON) r = x * y;
        else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0; m_result = 64'd0; m_zero = 1'b0; m_illegal = 1'b0;
    m_rd = 5'd0; m_fresh = 1'b1; m_mul_left = 0;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, m_valid});
    if (m_valid || m_fresh) begin
      chk({tag, ".result"},  result, m_result);
      chk({tag, ".zero"},    {63'd0, zero}, {63'd0, m_zero});
      chk({tag, ".illegal"}, {63'd0, illegal}, {63'd0, m_illegal});
      chk({tag, ".rd_out"},  {59'd0, rd_out}, {59'd0, m_rd});
    end
  endtask

  // One clock: drive, check in_ready, clock, update model, check outputs.
  task automatic step(input string tag, input bit iv, input logic [3:0] op,
                      input logic [63:0] x, input logic [63:0] y, input logic [4:0] rd,
                      input bit fl, input bit ordy, input bit r);
    bit          exp_ready;
    bit          ld;
    logic [63:0] res;
    bit          ill;
    logic [4:0]  ldrd;
    in_valid = iv; operation = op; a = x; b = y; rd_in = rd;
    flush = fl; out_ready = ordy; rst = r;
    #1;
    exp_ready = !fl && (m_mul_left == 0) && (!m_valid || ordy);
    chk({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, exp_ready});
    @(posedge clk);
    ld = 1'b0; res = 64'd0; ill = 1'b0; ldrd = 5'd0;
    if (r) begin
      model_reset();
    end else if (fl) begin
      m_valid = 1'b0;
      m_mul_left = 0;
    end else begin
      if (m_mul_left > 0) begin
        m_mul_left--;
        if (m_mul_left == 0) begin
          ld = 1'b1; res = m_mul_res; ill = 1'b0; ldrd = m_mul_rd;
        end
      end else if (iv && exp_ready) begin
        if (op == 4'b1000 && MUL_ON) begin
          m_mul_left = 64;
          m_mul_res  = x * y;
          m_mul_rd   = rd;
        end else begin
          ref_alu(op, x, y, res, ill);
          ld = 1'b1; ldrd = rd;
        end
      end
      if (ld) begin
        m_valid = 1'b1; m_result = res; m_zero = (res == 64'd0);
        m_illegal = ill; m_rd = ldrd; m_fresh = 1'b0;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input bit ordy);
    step(tag, 1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 1'b0, ordy, 1'b0);
  endtask

  logic [3:0]  r_op;
  logic [63:0] r_a;
  logic [63:0] r_b;
  int          sel;

  initial begin
    // Initial reset (outputs unknown before the first edge, so not checked there)
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");

    // ADD 5+7 -> 12
    step("add_5_7", 1'b1, 4'b0010, 64'd5, 64'd7, 5'd3, 1'b0, 1'b1, 1'b0);
    chk("add_5_7.const", result, 64'd12);
    chk("add_5_7.rd_const", {59'd0, rd_out}, 64'd3);
    // SUB 9-9 -> 0, zero
    step("sub_9_9", 1'b1, 4'b0110, 64'd9, 64'd9, 5'd4, 1'b0, 1'b1, 1'b0);
    chk("sub_9_9.zero_const", {63'd0, zero}, 64'd1);
    // SLT -1 < 1 -> 1
    step("slt_m1_1", 1'b1, 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5, 1'b0, 1'b1, 1'b0);
    chk("slt_m1_1.const", result, 64'd1);
    // ADD wrap
    step("add_wrap", 1'b1, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd6, 1'b0, 1'b1, 1'b0);
    chk("add_wrap.const", result, 64'd0);
    // NOR and an undefined code
    step("nor", 1'b1, 4'b1100, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 5'd7, 1'b0, 1'b1, 1'b0);
    step("illegal_op", 1'b1, 4'b1111, 64'd3, 64'd4, 5'd8, 1'b0, 1'b1, 1'b0);
    chk("illegal_op.const", {63'd0, illegal}, 64'd1);
    idle("drain", 1'b1);

    // Back-to-back AND then OR with downstream stalled for 3 cycles
    step("bb_and", 1'b1, 4'b0000, 64'hF0F0, 64'hFF00, 5'd9, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("bb_stall", 1'b1, 4'b0001, 64'hF0F0, 64'h0F0F, 5'd10, 1'b0, 1'b0, 1'b0);
    chk("bb_stall.held", result, 64'hF000);
    step("bb_or", 1'b1, 4'b0001, 64'hF0F0, 64'h0F0F, 5'd10, 1'b0, 1'b1, 1'b0);
    chk("bb_or.const", result, 64'hFFFF);
    idle("drain2", 1'b1);

    // MUL 6*7 (42 with macro, illegal without)
    step("mul_acc", 1'b1, 4'b1000, 64'd6, 64'd7, 5'd11, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) idle("mul_wait", 1'b1);
    idle("mul_after", 1'b1);

    // MUL flushed in its 10th cycle, then ADD 1+1
    step("mulf_acc", 1'b1, 4'b1000, 64'd3, 64'd5, 5'd12, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) idle("mulf_wait", 1'b1);
    step("mulf_flush", 1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) idle("mulf_quiet", 1'b1);
    step("add_1_1", 1'b1, 4'b0010, 64'd1, 64'd1, 5'd13, 1'b0, 1'b1, 1'b0);
    chk("add_1_1.const", result, 64'd2);

    // Flush beats an offered op
    step("flush_offer", 1'b1, 4'b0010, 64'd4, 64'd4, 5'd14, 1'b1, 1'b1, 1'b0);

    // Reset while a result is stalled
    step("rst_load", 1'b1, 4'b0001, 64'd1, 64'd2, 5'd15, 1'b0, 1'b0, 1'b0);
    step("rst_stalled", 1'b0, 4'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_stalled.result_const", result, 64'd0);
    chk("rst_stalled.rd_const", {59'd0, rd_out}, 64'd0);

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 15);
      case (sel)
        0, 1:    r_op = 4'b0000;
        2, 3:    r_op = 4'b0001;
        4, 5, 6: r_op = 4'b0010;
        7, 8:    r_op = 4'b0110;
        9, 10:   r_op = 4'b0111;
        11:      r_op = 4'b1100;
        12:      r_op = ($urandom_range(0, 3) == 0) ? 4'b1000 : 4'b0010;
        default: r_op = 4'($urandom);
      endcase
      r_a = {$urandom, $urandom};
      r_b = ($urandom_range(0, 5) == 0) ? r_a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) r_a = 64'($urandom_range(0, 20));
      step("rand", 1'($urandom), r_op, r_a, r_b, 5'($urandom),
           ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 150) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
